// File: rtl/router_in_arbiter.sv
// Round-robin arbiter that shares the router's single byte-wide input among
// NUM_SRC packet sources, granting one source for a whole framed packet.
module router_in_arbiter #(
    parameter int unsigned NUM_SRC = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [NUM_SRC-1:0]     gnt,
    output logic [7:0]             rtr_data_in,
    output logic                   rtr_pkt_valid,
    input  logic                   rtr_busy,
    output logic                   pkt_done,
    output logic                   hdr_addr_err,
    output logic                   proto_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 hdr_err_q, hdr_err_d;
    logic                 proto_q, proto_d;

    logic                 active;
    logic                 xfer;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_valid;
    logic [IDX_W-1:0]     cand;
    logic                 found;

    assign active = (state_q != IDLE);

    // One-hot mux of the granted source's byte and valid
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (gnt_q[k]) begin
                sel_data  = src_data[k*DATA_W +: DATA_W];
                sel_valid = src_valid[k];
            end
        end
    end

    assign xfer          = active & sel_valid & ~rtr_busy;
    assign src_ready     = gnt_q & {NUM_SRC{active & ~rtr_busy}};
    assign rtr_data_in   = active ? sel_data : '0;
    assign rtr_pkt_valid = (state_q == HDR) || (state_q == PAY);

    assign gnt          = gnt_q;
    assign pkt_done     = pkt_done_q;
    assign hdr_addr_err = hdr_err_q;
    assign proto_err    = proto_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        g_d        = g_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        pkt_done_d = 1'b0;
        hdr_err_d  = 1'b0;
        proto_d    = proto_q | (active & ~rtr_busy & ~sel_valid);
        cand       = '0;
        found      = 1'b0;

        case (state_q)
            IDLE: begin
                for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                    cand = IDX_W'((32'(last_q) + i) % NUM_SRC);
                    if (!found && src_req[cand]) begin
                        found   = 1'b1;
                        g_d     = cand;
                        gnt_d   = NUM_SRC'(1) << cand;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (xfer) begin
                    cnt_d     = sel_data[7:2];
                    hdr_err_d = (sel_data[1:0] == 2'b11);
                    state_d   = (sel_data[7:2] == '0) ? PAR : PAY;
                end
            end
            PAY: begin
                if (xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (xfer) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    last_d     = g_q;
                    pkt_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            g_q        <= '0;
            last_q     <= IDX_W'(NUM_SRC - 1);
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            hdr_err_q  <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            g_q        <= g_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            pkt_done_q <= pkt_done_d;
            hdr_err_q  <= hdr_err_d;
            proto_q    <= proto_d;
        end
    end

endmodule

// File: doc/router_in_arbiter.md
Name: router_in_arbiter

Overview:
Round-robin packet arbiter that shares the router13 single input port (data_in / pkt_valid / busy) among NUM_SRC packet sources. It grants one source for a whole packet: header {len[5:0], addr[1:0]}, len payload bytes, then the XOR parity byte. It generates the router's pkt_valid framing itself, tracking the payload count taken from the header. It obeys the router's busy backpressure byte by byte.

Parameters:
NUM_SRC, 3, number of packet sources (2..4).

Ports:
clk  input  1  system clock; all logic on posedge.
resetn  input  1  synchronous active-low reset.
src_req  input  NUM_SRC  source k has a packet pending.
src_valid  input  NUM_SRC  source k is presenting a byte on its src_data slice.
src_data  input  8*NUM_SRC  source k byte on bits [8k+7:8k].
src_ready  output  NUM_SRC  source k byte is consumed at this posedge.
gnt  output  NUM_SRC  one-hot registered grant; all zero when idle.
rtr_data_in  output  8  to router data_in.
rtr_pkt_valid  output  1  to router pkt_valid.
rtr_busy  input  1  from router busy.
pkt_done  output  1  one-cycle pulse after the parity byte is accepted.
hdr_addr_err  output  1  one-cycle pulse when an accepted header has addr == 2'b11.
proto_err  output  1  sticky; the granted source failed to supply a byte when one was required.

Behaviour:
- Reset, sampled at posedge with resetn=0, applies from the next cycle:
  - state IDLE; gnt=0; src_ready=0.
  - rtr_pkt_valid=0; rtr_data_in=0.
  - pkt_done=0; hdr_addr_err=0; proto_err=0.
  - RR pointer last=NUM_SRC-1, so source 0 has first priority.
- Reset mid-packet aborts immediately. No partial-packet completion. The router shares resetn.
- Transfer condition: a byte transfers on a posedge where state is HDR, PAY or PAR, gnt[g]=1, src_valid[g]=1 and rtr_busy=0.
- src_ready[k] = gnt[k] & (state in HDR/PAY/PAR) & ~rtr_busy. This is combinational.
- rtr_data_in = src_data[g] in HDR/PAY/PAR, else 8'h00. This is a combinational mux, so the byte is held for as long as the source holds it while busy.
- rtr_pkt_valid = 1 in HDR and PAY, 0 in PAR and IDLE. It does not depend on src_valid.
- FSM:
  - IDLE: if any src_req bit is set, pick the first requester after last, wrapping modulo NUM_SRC. Register gnt, go to HDR. Otherwise stay. Requests are evaluated only in IDLE, so there is one dead cycle between packets.
  - HDR: on transfer, load cnt=src_data[g][7:2]. Pulse hdr_addr_err next cycle if src_data[g][1:0]==2'b11; the packet is still forwarded. Go to PAR if cnt==0, else PAY.
  - PAY: on transfer, cnt decrements; when cnt==1 at transfer, go to PAR.
  - PAR: on transfer, go to IDLE. gnt clears at the same edge, last=g, and pkt_done pulses in the following cycle.
- Latency:
  - src_req seen at edge t gives gnt at t+1.
  - The header can transfer at edge t+2 at the earliest.
  - A len-L packet needs L+2 transfers.
- Backpressure: while rtr_busy=1, no transfer; cnt and state are frozen. rtr_busy in IDLE does not block granting.
- proto_err: set when state is HDR, PAY or PAR with rtr_busy=0 and src_valid[g]=0. It stays set until reset; the FSM waits in place. Gaps are illegal because the router consumes every non-busy cycle.
- src_req is ignored for a source mid-packet. A source may keep src_req high for back-to-back packets; round-robin still rotates.
- Counter width: 6 bits, so len 0..63 are all legal.

Test Plan:
1. Source 0 sends header 8'h38 (len 14, addr 0), 14 random bytes, then parity: 16 transfers. rtr_pkt_valid=1 for 15 accepted bytes and 0 for parity. Expect gnt=3'b001 throughout, pkt_done one cycle after parity, then gnt=0, and vld_out_0 in the router.
2. Force rtr_busy=1 for 3 cycles mid-payload: src_ready=0 and rtr_data_in holds the byte; the remaining count is unchanged; the packet completes with exactly 16 transfers.
3. All sources hold src_req with len-1 packets (header 8'h05): grant order is 0,1,2,0,… with one IDLE cycle between packets and each packet 3 transfers.
4. Header 8'h01 (len 0, addr 1): HDR goes straight to PAR with 2 transfers; rtr_pkt_valid is high for 1 cycle, then low for parity.
5. Header 8'h0B (len 2, addr 3): hdr_addr_err pulses once and the packet is still forwarded with 4 transfers.
6. Drop src_valid for one non-busy cycle mid-payload: proto_err goes to 1 and stays 1. Then resetn=0 mid-packet: the next cycle has gnt=0, rtr_pkt_valid=0, proto_err=0, and the FSM in IDLE.
